data_memory_ls: RTL and testbench
=================================

# data_memory_ls

Parametrised, byte-addressed data memory for the CPU load/store path, the next generation of the single-cycle word memory. It supports byte/half/word/full-width accesses with byte-lane write masking and sign or zero extension on loads. It has a registered valid/ready request-response handshake, alignment and range error reporting, and a post-reset clearing sequence that zeroes every word.

## Interface
- DATA_WIDTH, 32, word width in bits; legal values 32 or 64.
- DEPTH, 1024, number of words; any value ≥ 2.
- ADDR_WIDTH, 12, byte-address width; must satisfy DEPTH·(DATA_WIDTH/8) ≤ 2^ADDR_WIDTH.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = 32-bit word, 3 = full DATA_WIDTH.
- req_signed  in  1  load sign-extends when 1, zero-extends when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified (lane 0 = LSBs).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access was misaligned or out of range.

## Operation
- States: CLEAR, IDLE, RESP.
- Reset (async) forces CLEAR, clear counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0.
- CLEAR: writes 0 to word[counter] each cycle, increments. After word DEPTH−1 is written → IDLE. Takes exactly DEPTH cycles. req_ready = 0 throughout.
- Accept = req_valid && req_ready. req_ready = 1 in IDLE, and in RESP only when rsp_ready = 1 (single-entry output register, full-throughput chaining).
- Word index = req_addr >> log2(DATA_WIDTH/8); lane offset = low address bits.
- Error if req_addr not aligned to the access size (size 1: bit0 ≠ 0; size 2: bits[1:0] ≠ 0; size 3: all lane bits ≠ 0), or word index ≥ DEPTH. An erroring access performs no write and returns rsp_rdata = 0, rsp_err = 1.
- Size 3 with DATA_WIDTH = 32 behaves as size 2.
- Store: only the addressed byte lanes are updated, with the low bytes of req_wdata; other lanes are unchanged. Response has rsp_rdata = 0, rsp_err = 0.
- Load: select the addressed bytes and shift them to the LSBs. Extend to DATA_WIDTH: sign-extend from the top selected bit if req_signed, else zero-fill. req_signed is ignored at full width.
- On accept → RESP with the response registered. In RESP: if rsp_ready and no new accept → IDLE; if rsp_ready and new accept → stay RESP with new response; if !rsp_ready → hold all rsp_* outputs stable.
- Memory contents are not reset except via the CLEAR sequence.

## Timing
- Load latency 1: accept at edge N, rsp_valid and data visible after edge N.
- Store takes effect at the accept edge. A load accepted on any later edge returns the new data; back-to-back store→load to the same address returns the stored value.
- reset asserted mid-transaction: the response is dropped, the pending store (if not yet at its edge) is lost, and CLEAR restarts from 0.
- The first request can be accepted on cycle DEPTH after reset deassertion.

## Test plan
- Reset, DEPTH = 16 → req_ready stays 0 for 16 cycles, then 1. Full-width load of every address returns 0 with rsp_err = 0.
- Store word 0xDEADBEEF @0x8, then load word @0x8 → 0xDEADBEEF. Load byte signed @0x9 → 0xFFFFFFBE; unsigned → 0x000000BE.
- Store byte 0x11 @0xA over 0xDEADBEEF → load word @0x8 = 0xDE11BEEF. Store half 0x7F00 @0x8 → load half signed @0x8 = 0x00007F00.
- Load half @0x3 and store word @0x6 → rsp_err = 1, rsp_rdata = 0, and memory unchanged on readback. Word index 16 (@0x40, DEPTH = 16) → rsp_err = 1.
- Hold rsp_ready = 0 for 3 cycles with req_valid = 1 → req_ready = 0 and the response stays stable. Release → the next request is accepted on the same edge the response is consumed.
- Assert reset during RESP → rsp_valid = 0 immediately, CLEAR re-runs, and prior data reads back 0.

Source files
------------

// File: rtl/data_memory_ls_if.sv
// Load/store request-response bus between a CPU pipeline and data_memory_ls.
// Requests use a valid/ready handshake; responses come from a single registered entry.
interface data_memory_ls_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_ls.sv
// Byte-addressed data memory with lane-masked stores, extending loads, a registered
// response and a post-reset sweep that zeroes every word before requests are taken.
module data_memory_ls #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  data_memory_ls_if.slave  bus
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NB);
  localparam int IDX_W     = ADDR_WIDTH - LANE_BITS;
  localparam int CNT_W     = $clog2(DEPTH);
  localparam int TOP_W     = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {CLEAR, IDLE, RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  acc_err;
  logic                  store_en;
  logic [1:0]            eff_size;
  logic [LANE_BITS-1:0]  lane_off;
  logic [LANE_BITS-1:0]  align_mask;
  logic [IDX_W-1:0]      word_idx;
  logic [CNT_W-1:0]      mem_idx;
  logic [NB-1:0]         size_lanes;
  logic [NB-1:0]         lane_mask;
  logic [DATA_WIDTH-1:0] wdata_shifted;
  logic [DATA_WIDTH-1:0] raw_word;
  logic [DATA_WIDTH-1:0] data_mask;
  logic [DATA_WIDTH-1:0] load_data;
  logic [TOP_W-1:0]      top_bit;

  // The output register is single-entry, so a new request only fits while the old response leaves.
  assign bus.req_ready = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign store_en      = accept && bus.req_we && !acc_err;

  always_comb begin
    eff_size = bus.req_size;
    if ((DATA_WIDTH == 32) && (bus.req_size == 2'd3)) eff_size = 2'd2;

    lane_off = bus.req_addr[LANE_BITS-1:0];
    word_idx = bus.req_addr[ADDR_WIDTH-1:LANE_BITS];
    mem_idx  = bus.req_addr[LANE_BITS +: CNT_W];

    case (eff_size)
      2'd0: begin size_lanes = NB'(1);  align_mask = '0;               top_bit = TOP_W'(7);  end
      2'd1: begin size_lanes = NB'(3);  align_mask = LANE_BITS'(1);    top_bit = TOP_W'(15); end
      2'd2: begin size_lanes = NB'(15); align_mask = LANE_BITS'(3);    top_bit = TOP_W'(31); end
      default: begin size_lanes = '1;   align_mask = '1;               top_bit = TOP_W'(DATA_WIDTH-1); end
    endcase

    misaligned   = |(lane_off & align_mask);
    out_of_range = {1'b0, word_idx} >= (IDX_W+1)'(DEPTH);
    acc_err      = misaligned || out_of_range;

    lane_mask     = size_lanes << lane_off;
    wdata_shifted = bus.req_wdata << {lane_off, 3'b000};
    raw_word      = mem[mem_idx] >> {lane_off, 3'b000};

    for (int i = 0; i < NB; i++) begin
      data_mask[8*i +: 8] = {8{size_lanes[i]}};
    end
    // At full width data_mask is all ones, so the extension term vanishes and req_signed has no effect.
    load_data = raw_word & data_mask;
    if (bus.req_signed && raw_word[top_bit]) load_data = load_data | ~data_mask;
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == CNT_W'(DEPTH-1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_W'(1);
        end
      end
      IDLE, RESP: begin
        if ((state_q == RESP) && bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
        if (accept) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || bus.req_we) ? '0 : load_data;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Storage is deliberately outside the reset domain; only the CLEAR sweep zeroes it.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (store_en) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_mask[i]) mem[mem_idx][8*i +: 8] <= wdata_shifted[8*i +: 8];
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_memory_ls.sv
// Self-checking bench for data_memory_ls: directed vector table, handshake corner cases
// and random traffic compared against a byte-array reference model.
module tb_data_memory_ls;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 16;
  localparam int NB    = DW / 8;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  data_memory_ls_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory_ls #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          sgn;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] expRdata;
    logic          expErr;
  } vec_t;

  logic [7:0] modelMem [DEPTH*NB];

  function automatic vec_t mkVec(logic we, logic [1:0] size, logic sgn, logic [AW-1:0] addr,
                                 logic [DW-1:0] wdata, logic [DW-1:0] er, logic ee);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.expRdata = er; v.expErr = ee;
    return v;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < DEPTH*NB; i++) modelMem[i] = 8'h00;
  endfunction

  // Reference behaviour: an access touches nb consecutive bytes starting at addr.
  function automatic void modelAccess(input logic we, input logic [1:0] size, input logic sgn,
                                      input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                      output logic [DW-1:0] rdata, output logic err);
    int nb;
    int a;
    logic [63:0] v;
    nb = (size == 2'd3) ? NB : (1 << size);
    a  = int'(addr);
    err = ((a % nb) != 0) || ((a / NB) >= DEPTH);
    rdata = '0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < nb; b++) modelMem[a+b] = wdata[8*b +: 8];
      end else begin
        v = 64'd0;
        for (int b = 0; b < nb; b++) v[8*b +: 8] = modelMem[a+b];
        if (sgn && (nb < NB) && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        rdata = v[DW-1:0];
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete transaction; stall holds rsp_ready low for that many cycles after accept.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input int stall, output logic [DW-1:0] rdata, output logic err);
    int waitCnt;
    rdata = '0;
    err   = 1'b0;
    @(negedge clk);
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    bus.rsp_ready  = (stall == 0);
    waitCnt = 0;
    while (!bus.req_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("req_ready", 64'(bus.req_ready), 64'd1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int s = 0; s < stall; s++) @(negedge clk);
    checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic countClear(input string name);
    int n;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(n), 64'(DEPTH));
  endtask

  vec_t          vecs[19];
  logic [DW-1:0] got, expD;
  logic          gotErr, expE;
  logic [1:0]    rSize;
  logic [AW-1:0] rAddr;
  logic          rWe, rSgn;
  logic [DW-1:0] rData;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    modelClear();

    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    checkOutput("reset_rsp_err",   64'(bus.rsp_err),   64'd0);
    reset = 1'b0;
    countClear("clear_cycles");

    for (int w = 0; w < DEPTH; w++) begin
      applyStimulus(1'b0, 2'd3, 1'b0, AW'(w*NB), '0, 0, got, gotErr);
      checkOutput($sformatf("cleared_word%0d", w), 64'(got), 64'd0);
      checkOutput($sformatf("cleared_err%0d", w), 64'(gotErr), 64'd0);
    end

    vecs[0]  = mkVec(1, 2'd2, 0, 12'h008, 32'hDEADBEEF, 32'h00000000, 0);
    vecs[1]  = mkVec(0, 2'd2, 0, 12'h008, 32'h0,        32'hDEADBEEF, 0);
    vecs[2]  = mkVec(0, 2'd0, 1, 12'h009, 32'h0,        32'hFFFFFFBE, 0);
    vecs[3]  = mkVec(0, 2'd0, 0, 12'h009, 32'h0,        32'h000000BE, 0);
    vecs[4]  = mkVec(1, 2'd0, 0, 12'h00A, 32'h00000011, 32'h00000000, 0);
    vecs[5]  = mkVec(0, 2'd2, 0, 12'h008, 32'h0,        32'hDE11BEEF, 0);
    vecs[6]  = mkVec(1, 2'd1, 0, 12'h008, 32'h00007F00, 32'h00000000, 0);
    vecs[7]  = mkVec(0, 2'd1, 1, 12'h008, 32'h0,        32'h00007F00, 0);
    vecs[8]  = mkVec(0, 2'd2, 0, 12'h008, 32'h0,        32'hDE117F00, 0);
    vecs[9]  = mkVec(0, 2'd1, 0, 12'h003, 32'h0,        32'h00000000, 1);
    vecs[10] = mkVec(1, 2'd2, 0, 12'h006, 32'h12345678, 32'h00000000, 1);
    vecs[11] = mkVec(0, 2'd2, 0, 12'h004, 32'h0,        32'h00000000, 0);
    vecs[12] = mkVec(0, 2'd2, 0, 12'h008, 32'h0,        32'hDE117F00, 0);
    vecs[13] = mkVec(0, 2'd2, 0, 12'h040, 32'h0,        32'h00000000, 1);
    vecs[14] = mkVec(1, 2'd0, 0, 12'h040, 32'h000000AA, 32'h00000000, 1);
    vecs[15] = mkVec(0, 2'd3, 1, 12'h008, 32'h0,        32'hDE117F00, 0);
    vecs[16] = mkVec(0, 2'd1, 1, 12'h00A, 32'h0,        32'hFFFFDE11, 0);
    vecs[17] = mkVec(0, 2'd0, 1, 12'h00B, 32'h0,        32'hFFFFFFDE, 0);
    vecs[18] = mkVec(0, 2'd3, 0, 12'h002, 32'h0,        32'h00000000, 1);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, 0, got, gotErr);
      modelAccess(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, expD, expE);
      checkOutput($sformatf("vec%0d_rdata", i), 64'(got), 64'(vecs[i].expRdata));
      checkOutput($sformatf("vec%0d_err", i), 64'(gotErr), 64'(vecs[i].expErr));
    end

    // Backpressure: response must hold while rsp_ready is low, then chain on release.
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0; bus.req_addr = 12'h008;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_size = 2'd0; bus.req_addr = 12'h00B;
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_req_ready", 64'(bus.req_ready), 64'd0);
      checkOutput("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      checkOutput("bp_rsp_rdata", 64'(bus.rsp_rdata), 64'hDE117F00);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("bp_chain_valid", 64'(bus.rsp_valid), 64'd1);
    checkOutput("bp_chain_rdata", 64'(bus.rsp_rdata), 64'h000000DE);
    @(negedge clk);
    checkOutput("bp_idle_valid", 64'(bus.rsp_valid), 64'd0);

    // Back-to-back store then load to the same word with no idle cycle between.
    bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_addr = 12'h020; bus.req_wdata = 32'hA5A55A5A;
    bus.req_valid = 1'b1;
    modelAccess(1'b1, 2'd2, 1'b0, 12'h020, 32'hA5A55A5A, expD, expE);
    @(negedge clk);
    checkOutput("chain_store_err", 64'(bus.rsp_err), 64'd0);
    checkOutput("chain_store_rdata", 64'(bus.rsp_rdata), 64'd0);
    checkOutput("chain_ready", 64'(bus.req_ready), 64'd1);
    bus.req_we = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("chain_load_rdata", 64'(bus.rsp_rdata), 64'hA5A55A5A);

    for (int i = 0; i < 200; i++) begin
      rWe   = 1'($urandom_range(0, 1));
      rSgn  = 1'($urandom_range(0, 1));
      rSize = 2'($urandom_range(0, 3));
      rAddr = AW'($urandom_range(0, DEPTH*NB + 15));
      if ($urandom_range(0, 2) != 0) rAddr = rAddr & ~AW'((1 << rSize) - 1);
      rData = $urandom;
      applyStimulus(rWe, rSize, rSgn, rAddr, rData, $urandom_range(0, 2), got, gotErr);
      modelAccess(rWe, rSize, rSgn, rAddr, rData, expD, expE);
      checkOutput($sformatf("rand%0d_rdata", i), 64'(got), 64'(expD));
      checkOutput($sformatf("rand%0d_err", i), 64'(gotErr), 64'(expE));
    end

    // Reset while a response is pending, then the sweep must wipe earlier stores.
    applyStimulus(1'b1, 2'd2, 1'b0, 12'h010, 32'hCAFEF00D, 0, got, gotErr);
    modelAccess(1'b1, 2'd2, 1'b0, 12'h010, 32'hCAFEF00D, expD, expE);
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 12'h010;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("prereset_valid", 64'(bus.rsp_valid), 64'd1);
    checkOutput("prereset_rdata", 64'(bus.rsp_rdata), 64'hCAFEF00D);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("midreset_rdata", 64'(bus.rsp_rdata), 64'd0);
    checkOutput("midreset_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    modelClear();
    countClear("reclear_cycles");
    applyStimulus(1'b0, 2'd2, 1'b0, 12'h010, '0, 0, got, gotErr);
    checkOutput("reclear_word4", 64'(got), 64'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 12'h008, '0, 0, got, gotErr);
    checkOutput("reclear_word2", 64'(got), 64'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 12'h020, '0, 0, got, gotErr);
    checkOutput("reclear_word8", 64'(got), 64'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
